// File: rtl/uart_pkg.sv
// Shared constants for the configurable UART blocks.
// FSM state codes, parity modes and frame sizing helper.
package uart_pkg;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE   = 3'd0;
  localparam state_t S_START  = 3'd1;
  localparam state_t S_DATA   = 3'd2;
  localparam state_t S_PARITY = 3'd3;
  localparam state_t S_STOP   = 3'd4;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  function automatic int frame_bits(
    input int data_bits,
    input int parity,
    input int stop_bits
  );
    int par;
    par = (parity != PAR_NONE) ? 1 : 0;
    return 1 + data_bits + par + stop_bits;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period counter: counts 0..div-1 and flags the last cycle.
// Shared between the TX and the planned RX.
module uart_baud_tick #(
  parameter int DIV_BITS = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load,
  input  logic                en,
  input  logic [DIV_BITS-1:0] div,
  output logic                tick,
  output logic [DIV_BITS-1:0] count
);

  assign tick = en && (count == div - DIV_BITS'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load || tick || !en) begin
      count <= '0;
    end else begin
      count <= count + DIV_BITS'(1);
    end
  end

endmodule

// File: rtl/uart_tx_cfg.sv
// Configurable UART transmitter with valid/ready input.
// Data width, parity and stop bits fixed at build; baud set per frame.
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1,
  parameter int DIV_BITS  = 16
) (
  input  logic                 i_Clock,
  input  logic                 i_Reset_n,
  input  logic [DIV_BITS-1:0]  i_Clks_Per_Bit,
  input  logic                 i_Tx_Valid,
  input  logic [DATA_BITS-1:0] i_Tx_Data,
  output logic                 o_Tx_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done
);

  localparam int IW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(DATA_BITS - 1);
  localparam logic [DIV_BITS-1:0] MIN_DIV = DIV_BITS'(2);

  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
    $error("uart_tx_cfg: PARITY must be 0, 1 or 2");
  end
  if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  if (DIV_BITS < 2) begin : g_bad_div
    $error("uart_tx_cfg: DIV_BITS must be at least 2");
  end

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [DATA_BITS-1:0]   shreg;
  logic                   par_q;
  logic [DIV_BITS-1:0]    div_q;
  logic                   stop_idx;
  logic                   serial;
  logic                   active;
  logic                   done;

  logic                   xfer;
  logic                   tick;
  logic                   busy;
  logic [DIV_BITS-1:0]    count;
  logic                   last_stop;
  logic                   pre_end;

  assign o_Tx_Ready  = (state == S_IDLE);
  assign o_Tx_Serial = serial;
  assign o_Tx_Active = active;
  assign o_Tx_Done   = done;

  assign xfer = i_Tx_Valid && o_Tx_Ready;
  assign busy = (state != S_IDLE);

  assign last_stop = (STOP_BITS == 1) || stop_idx;

  // Done is registered, so it is armed one cycle before the frame ends.
  assign pre_end = (state == S_STOP) && last_stop &&
                   (count == div_q - MIN_DIV);

  uart_baud_tick #(
    .DIV_BITS(DIV_BITS)
  ) u_baud (
    .clk  (i_Clock),
    .rst_n(i_Reset_n),
    .load (xfer),
    .en   (busy),
    .div  (div_q),
    .tick (tick),
    .count(count)
  );

  always_ff @(posedge i_Clock or negedge i_Reset_n) begin
    if (!i_Reset_n) begin
      state    <= S_IDLE;
      serial   <= 1'b1;
      active   <= 1'b0;
      done     <= 1'b0;
      idx      <= '0;
      stop_idx <= 1'b0;
      shreg    <= '0;
      par_q    <= 1'b0;
      div_q    <= MIN_DIV;
    end else begin
      done <= pre_end;
      case (state)
        S_IDLE: begin
          serial <= 1'b1;
          if (xfer) begin
            state  <= S_START;
            serial <= 1'b0;
            active <= 1'b1;
            shreg  <= i_Tx_Data;
            par_q  <= (PARITY == PAR_EVEN) ?
                      ^i_Tx_Data : ~^i_Tx_Data;
            div_q  <= (i_Clks_Per_Bit < MIN_DIV) ?
                      MIN_DIV : i_Clks_Per_Bit;
          end
        end
        S_START: begin
          if (tick) begin
            state  <= S_DATA;
            idx    <= '0;
            serial <= shreg[0];
            shreg  <= shreg >> 1;
          end
        end
        S_DATA: begin
          if (tick) begin
            if (idx == LAST_IDX) begin
              idx      <= '0;
              stop_idx <= 1'b0;
              if (PARITY != PAR_NONE) begin
                state  <= S_PARITY;
                serial <= par_q;
              end else begin
                state  <= S_STOP;
                serial <= 1'b1;
              end
            end else begin
              idx    <= idx + 1'b1;
              serial <= shreg[0];
              shreg  <= shreg >> 1;
            end
          end
        end
        S_PARITY: begin
          if (tick) begin
            state    <= S_STOP;
            serial   <= 1'b1;
            stop_idx <= 1'b0;
          end
        end
        S_STOP: begin
          if (tick) begin
            if (last_stop) begin
              state  <= S_IDLE;
              active <= 1'b0;
            end else begin
              stop_idx <= 1'b1;
            end
          end
        end
        default: begin
          state    <= S_IDLE;
          serial   <= 1'b1;
          active   <= 1'b0;
          idx      <= '0;
          stop_idx <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg across four frame formats.
// Expected per-cycle line/handshake state is built from the frame rules.
module tb_uart_tx_cfg;

  localparam int NDUT = 4;
  localparam int RING = 16384;
  localparam int DBV  [NDUT] = '{8, 8, 8, 7};
  localparam int PARV [NDUT] = '{0, 2, 1, 0};
  localparam int SBV  [NDUT] = '{1, 1, 1, 2};
  localparam logic [3:0] IDLE_V = 4'b1001;

  logic clk;
  logic rst_n;
  logic [NDUT-1:0] vld;
  logic [8:0]      dat [NDUT];
  logic [15:0]     cpb [NDUT];
  logic [NDUT-1:0] rdy;
  logic [NDUT-1:0] ser;
  logic [NDUT-1:0] act;
  logic [NDUT-1:0] dn;

  logic [3:0] ring [NDUT][RING];
  int wr [NDUT];
  int rd [NDUT];
  int errors;
  int checks;
  int nprint;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    uart_tx_cfg #(
      .DATA_BITS(DBV[g]),
      .PARITY   (PARV[g]),
      .STOP_BITS(SBV[g]),
      .DIV_BITS (16)
    ) u_dut (
      .i_Clock       (clk),
      .i_Reset_n     (rst_n),
      .i_Clks_Per_Bit(cpb[g]),
      .i_Tx_Valid    (vld[g]),
      .i_Tx_Data     (dat[g][DBV[g]-1:0]),
      .o_Tx_Ready    (rdy[g]),
      .o_Tx_Serial   (ser[g]),
      .o_Tx_Active   (act[g]),
      .o_Tx_Done     (dn[g])
    );
  end

  // Expected vector per cycle: {ready, active, done, serial}.
  function automatic void push_frame(
    input int k,
    input logic [8:0] d,
    input logic [15:0] div
  );
    int de;
    int ones;
    int nb;
    logic bits [$];
    de = (div < 16'd2) ? 2 : int'(div);
    ones = 0;
    bits.push_back(1'b0);
    for (int i = 0; i < DBV[k]; i++) begin
      bits.push_back(d[i]);
      ones += int'(d[i]);
    end
    if (PARV[k] == 2) bits.push_back(ones % 2 == 1);
    if (PARV[k] == 1) bits.push_back(ones % 2 == 0);
    for (int s = 0; s < SBV[k]; s++) bits.push_back(1'b1);
    nb = bits.size();
    for (int i = 0; i < nb; i++) begin
      for (int j = 0; j < de; j++) begin
        ring[k][wr[k]] = {1'b0, 1'b1,
                          (i == nb - 1) && (j == de - 1),
                          bits[i]};
        wr[k] = (wr[k] + 1) % RING;
      end
    end
  endfunction

  task automatic send(
    input int k,
    input logic [8:0] d,
    input logic [15:0] div,
    input bit hold
  );
    int n;
    n = 0;
    vld[k] = 1'b1;
    dat[k] = d;
    cpb[k] = div;
    while (!rdy[k] && n < 20000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!rdy[k]) begin
      errors++;
      $display("FAIL ready_timeout dut%0d got=0 want=1", k);
      vld[k] = 1'b0;
      return;
    end
    @(posedge clk);
    push_frame(k, d, div);
    @(negedge clk);
    if (!hold) vld[k] = 1'b0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
  endtask

  always @(negedge clk) begin
    logic [3:0] got;
    logic [3:0] want;
    for (int k = 0; k < NDUT; k++) begin
      got = {rdy[k], act[k], dn[k], ser[k]};
      if (!rst_n) begin
        rd[k] = wr[k];
        want = IDLE_V;
      end else if (rd[k] != wr[k]) begin
        want = ring[k][rd[k]];
        rd[k] = (rd[k] + 1) % RING;
      end else begin
        want = IDLE_V;
      end
      checks++;
      if (got !== want) begin
        errors++;
        if (nprint < 30) begin
          nprint++;
          $display("FAIL line dut%0d t=%0t rdy/act/done/ser got=%b want=%b",
                   k, $time, got, want);
        end
      end
    end
  end

  initial begin
    int n;
    bit busy;
    errors = 0;
    checks = 0;
    nprint = 0;
    vld = '0;
    for (int k = 0; k < NDUT; k++) begin
      dat[k] = '0;
      cpb[k] = 16'd4;
      wr[k] = 0;
      rd[k] = 0;
    end
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);

    send(0, 9'h0A5, 16'd4, 1'b0);
    send(1, 9'h007, 16'd4, 1'b0);
    send(2, 9'h007, 16'd4, 1'b0);
    send(3, 9'h07F, 16'd3, 1'b0);

    send(0, 9'h055, 16'd4, 1'b1);
    send(0, 9'h0AA, 16'd4, 1'b0);

    send(0, 9'h03C, 16'd868, 1'b0);
    repeat (100) @(negedge clk);
    cpb[0] = 16'd217;
    send(0, 9'h0C3, 16'd217, 1'b0);
    send(0, 9'h05A, 16'd0, 1'b0);
    send(0, 9'h0E1, 16'd1, 1'b0);

    send(0, 9'h096, 16'd4, 1'b0);
    repeat (17) @(negedge clk);
    pulse_reset();
    send(0, 9'h096, 16'd4, 1'b0);

    for (int b = 0; b < 30; b++) begin
      int k;
      int len;
      k = int'($urandom_range(0, NDUT - 1));
      len = int'($urandom_range(1, 3));
      for (int i = 0; i < len; i++) begin
        send(k, 9'($urandom), 16'($urandom_range(0, 6)), i != len - 1);
      end
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    n = 0;
    busy = 1'b1;
    while (busy && n < 30000) begin
      busy = 1'b0;
      for (int k = 0; k < NDUT; k++) if (rd[k] != wr[k]) busy = 1'b1;
      if (busy) begin
        @(negedge clk);
        n++;
      end
    end
    checks++;
    if (busy) begin
      errors++;
      $display("FAIL drain_timeout got=busy want=idle");
    end
    repeat (5) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
